// File: rtl/bus_timer_responder.sv
// RISC-V machine timer (mtime/mtimecmp) as a responder on the Ibex req/gnt/rvalid data bus.
// Optional prescaler on CTRL[15:8] enabled by defining BUS_TIMER_PRESCALER_EN.
module bus_timer_responder #(
    parameter logic [31:0] BaseAddr = 32'h0001_0000,
    parameter logic [31:0] AddrMask = 32'h0000_001F
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        irq_timer_o
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic        tick;
    logic [2:0]  off;
    logic        acc_ok, wr;
    logic [31:0] rd_word, ctrl_word;
    logic        rvalid_q, err_q, irq_q;
    logic [31:0] rdata_q;

`ifdef BUS_TIMER_PRESCALER_EN
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] pcnt_q, pcnt_d;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = nw[8*i +: 8];
        end
        return res;
    endfunction

    // Responses are always single-cycle, so nothing ever blocks a grant.
    assign gnt_o = req_i;

    assign off    = addr_i[4:2];
    assign acc_ok = ((addr_i & ~AddrMask) == BaseAddr) && (off <= 3'd4);
    assign wr     = req_i & we_i & acc_ok;

    always_comb begin
        ctrl_word = '0;
        ctrl_word[0] = en_q;
`ifdef BUS_TIMER_PRESCALER_EN
        ctrl_word[15:8] = prescale_q;
        tick = en_q && (pcnt_q == prescale_q);
`else
        tick = en_q;
`endif
        case (off)
            3'd0:    rd_word = mtime_q[31:0];
            3'd1:    rd_word = mtime_q[63:32];
            3'd2:    rd_word = mtimecmp_q[31:0];
            3'd3:    rd_word = mtimecmp_q[63:32];
            3'd4:    rd_word = ctrl_word;
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        mtime_d    = mtime_q + {63'd0, tick};
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
`ifdef BUS_TIMER_PRESCALER_EN
        prescale_d = prescale_q;
        if (!en_q || (wr && off == 3'd4)) pcnt_d = '0;
        else if (pcnt_q == prescale_q)    pcnt_d = '0;
        else                              pcnt_d = pcnt_q + 8'd1;
`endif
        // A software write to either mtime half replaces the whole increment for that cycle.
        if (wr) begin
            case (off)
                3'd0: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata_i, be_i)};
                3'd1: mtime_d = {merge(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
                3'd2: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdata_i, be_i);
                3'd3: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata_i, be_i);
                3'd4: begin
                    if (be_i[0]) en_d = wdata_i[0];
`ifdef BUS_TIMER_PRESCALER_EN
                    if (be_i[1]) prescale_d = wdata_i[15:8];
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
`ifdef BUS_TIMER_PRESCALER_EN
            prescale_q <= '0;
            pcnt_q     <= '0;
`endif
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            rvalid_q   <= req_i;
            err_q      <= req_i & ~acc_ok;
            rdata_q    <= (req_i && !we_i && acc_ok) ? rd_word : '0;
            irq_q      <= (mtime_q >= mtimecmp_q);
`ifdef BUS_TIMER_PRESCALER_EN
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
`endif
        end
    end

    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign irq_timer_o = irq_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Directed self-checking bench for bus_timer_responder; prescaler case runs when
// BUS_TIMER_PRESCALER_EN is defined.
module tb_bus_timer_responder;

    localparam logic [31:0] Base = 32'h0001_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        gnt_o, rvalid_o, err_o, irq_timer_o;
    logic [31:0] rdata_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] rd;
    logic        er;

    bus_timer_responder #(
        .BaseAddr(32'h0001_0000),
        .AddrMask(32'h0000_001F)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .irq_timer_o(irq_timer_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer: request presented at negedge, granted at the next posedge,
    // response sampled 1 ns after that edge.
    task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
        #1 check_eq("gnt", {63'd0, gnt_o}, 64'd1);
        @(posedge clk_i);
        #1;
        req_i = 1'b0; we_i = 1'b0;
        check_eq("rvalid", {63'd0, rvalid_o}, 64'd1);
        rdata = rdata_o;
        err   = err_o;
        if (we) check_eq("wr_rdata", {32'd0, rdata_o}, 64'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                          input logic exp_err);
        logic [31:0] d;
        logic        e;
        bus_xfer(1'b0, addr, 4'hF, 32'd0, d, e);
        check_eq(tag, {32'd0, d}, {32'd0, exp});
        check_eq({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        logic [31:0] d;
        logic        e;
        bus_xfer(1'b1, addr, be, data, d, e);
        check_eq("wr_err", {63'd0, e}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
        check_eq("rst_rdata", {32'd0, rdata_o}, 64'd0);
        check_eq("rst_err", {63'd0, err_o}, 64'd0);
        check_eq("rst_irq", {63'd0, irq_timer_o}, 64'd0);
        check_eq("rst_gnt", {63'd0, gnt_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        rd_chk("cmp_lo_rst", Base + 32'h08, 32'hFFFF_FFFF, 1'b0);
        rd_chk("cmp_hi_rst", Base + 32'h0C, 32'hFFFF_FFFF, 1'b0);
        rd_chk("ctrl_rst", Base + 32'h10, 32'h0, 1'b0);
        check_eq("irq_idle", {63'd0, irq_timer_o}, 64'd0);

        // Byte-enable merge and be=0 no-op on MTIMECMP_LO.
        wr(Base + 32'h08, 4'b0010, 32'h0000_AB00);
        rd_chk("cmp_lo_byte", Base + 32'h08, 32'hFFFF_ABFF, 1'b0);
        wr(Base + 32'h08, 4'b0000, 32'h1234_5678);
        rd_chk("cmp_lo_be0", Base + 32'h08, 32'hFFFF_ABFF, 1'b0);

        // Reserved offset and out-of-window accesses.
        rd_chk("rsvd_14", Base + 32'h14, 32'h0, 1'b1);
        rd_chk("rsvd_1c", Base + 32'h1C, 32'h0, 1'b1);
        rd_chk("outside", 32'h0002_0000, 32'h0, 1'b1);
        bus_xfer(1'b1, 32'h0002_0008, 4'hF, 32'h0, rd, er);
        check_eq("outside_wr_err", {63'd0, er}, 64'd1);
        rd_chk("cmp_lo_kept", Base + 32'h08, 32'hFFFF_ABFF, 1'b0);

        // irq rises 11 cycles after the CTRL write grant edge.
        wr(Base + 32'h08, 4'hF, 32'd10);
        wr(Base + 32'h0C, 4'hF, 32'd0);
        check_eq("irq_pre", {63'd0, irq_timer_o}, 64'd0);
        wr(Base + 32'h10, 4'hF, 32'd1);
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk_i);
            #1;
            if (i == 10) check_eq("irq_c10", {63'd0, irq_timer_o}, 64'd0);
            if (i == 11) check_eq("irq_c11", {63'd0, irq_timer_o}, 64'd1);
        end
        wr(Base + 32'h10, 4'hF, 32'd0);
        wr(Base + 32'h0C, 4'hF, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk_i);
        #1 check_eq("irq_cleared", {63'd0, irq_timer_o}, 64'd0);

        // 64-bit wrap: exactly one tick between enable and disable.
        wr(Base + 32'h00, 4'hF, 32'hFFFF_FFFF);
        wr(Base + 32'h04, 4'hF, 32'hFFFF_FFFF);
        wr(Base + 32'h10, 4'hF, 32'd1);
        wr(Base + 32'h10, 4'hF, 32'd0);
        rd_chk("wrap_hi", Base + 32'h04, 32'h0, 1'b0);
        rd_chk("wrap_lo", Base + 32'h00, 32'h0, 1'b0);

        // Write to MTIME_LO while counting drops that cycle's tick.
        wr(Base + 32'h10, 4'hF, 32'd1);
        wr(Base + 32'h00, 4'hF, 32'h0000_0100);
        wr(Base + 32'h10, 4'hF, 32'd0);
        rd_chk("wr_wins_lo", Base + 32'h00, 32'h0000_0101, 1'b0);
        rd_chk("wr_wins_hi", Base + 32'h04, 32'h0, 1'b0);

`ifdef BUS_TIMER_PRESCALER_EN
        wr(Base + 32'h00, 4'hF, 32'd0);
        wr(Base + 32'h10, 4'hF, 32'h0000_0301);
        repeat (40) @(posedge clk_i);
        rd_chk("presc_mtime", Base + 32'h00, 32'd10, 1'b0);
        rd_chk("presc_ctrl", Base + 32'h10, 32'h0000_0301, 1'b0);
`else
        wr(Base + 32'h10, 4'hF, 32'h0000_0300);
        rd_chk("ctrl_no_presc", Base + 32'h10, 32'h0, 1'b0);
`endif

        // Reset landing on a grant edge suppresses the response and clears state.
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = Base + 32'h08; be_i = 4'hF; rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        check_eq("rst_mid_rvalid", {63'd0, rvalid_o}, 64'd0);
        check_eq("rst_mid_rdata", {32'd0, rdata_o}, 64'd0);
        check_eq("rst_mid_irq", {63'd0, irq_timer_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd_chk("rst_mid_mtime", Base + 32'h00, 32'h0, 1'b0);
        rd_chk("rst_mid_cmp", Base + 32'h0C, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
